config_loader: RTL and testbench

- Synthesizable configuration sequencer that sits directly upstream of the fpga fabric.
- Accepts the bitstream as a valid/ready word stream and assembles each ROW_WIDTH-bit configuration row.
- Writes rows into the fabric with one-hot configs_en strobes, row 0 first.
- After the last row it waits a settle period, asserts ff_en, then asserts rdy.

---
 rtl/config_loader.sv | 84 ++++++++
 tb/tb_config_loader.sv | 130 +++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// config_loader: assembles word-stream rows, strobes them into the fabric, then enables flops and signals ready.
module config_loader #(
    parameter int ROW_WIDTH     = 224,
    parameter int NUM_ROWS      = 43,
    parameter int WORD_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 10,
    parameter int RDY_DELAY     = 10
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic [ROW_WIDTH-1:0]  configs_in,
    output logic [NUM_ROWS-1:0]   configs_en,
    output logic                  ff_en,
    output logic                  rdy,
    output logic                  busy
);
    localparam int WPR = ROW_WIDTH / WORD_WIDTH;
    localparam int WW  = $clog2(WPR + 1);
    localparam int RW  = $clog2(NUM_ROWS + 1);
    localparam int CMAX = SETTLE_CYCLES > RDY_DELAY ? SETTLE_CYCLES : RDY_DELAY;
    localparam int CW  = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, LOAD, COMMIT, STROBE, SETTLE, FFEN, DONE} state_t;

    state_t               state, state_n;
    logic [RW-1:0]        row;
    logic [WW-1:0]        word;
    logic [CW-1:0]        cnt;
    logic [ROW_WIDTH-1:0] asm_q, asm_n;
    logic                 take, last_word, last_row, cnt_done, go;

    always_comb begin
        in_ready   = state == LOAD;
        busy       = !(state == IDLE || state == DONE);
        ff_en      = state == FFEN || state == DONE;
        rdy        = state == DONE;
        configs_en = state == STROBE ? NUM_ROWS'(1) << row : '0;
        take       = in_ready && in_valid;
        last_word  = word == WW'(WPR - 1);
        last_row   = row == RW'(NUM_ROWS - 1);
        cnt_done   = cnt == CW'(state == SETTLE ? SETTLE_CYCLES - 1 : RDY_DELAY - 1);
        go         = start && (state == IDLE || state == DONE);
        asm_n      = asm_q;
        asm_n[word*WORD_WIDTH +: WORD_WIDTH] = in_data;
        state_n    = state;
        case (state)
            IDLE, DONE: state_n = go ? LOAD : state;
            LOAD:       state_n = take && last_word ? COMMIT : LOAD;
            COMMIT:     state_n = STROBE;
            STROBE:     state_n = last_row ? SETTLE : LOAD;
            SETTLE:     state_n = cnt_done ? FFEN : SETTLE;
            FFEN:       state_n = cnt_done ? DONE : FFEN;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Restart clears the datapath on the same edge the FSM re-enters LOAD
    always_ff @(posedge clock) begin
        if (rst || go) begin
            row        <= '0;
            word       <= '0;
            cnt        <= '0;
            asm_q      <= '0;
            configs_in <= '0;
        end else begin
            if (take) begin
                asm_q <= asm_n;
                word  <= last_word ? '0 : word + 1'b1;
                if (last_word) configs_in <= asm_n;
            end
            if (state == STROBE && !last_row) row <= row + 1'b1;
            cnt <= (state == SETTLE || state == FFEN) && !cnt_done ? cnt + 1'b1 : '0;
        end
    end
endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: directed checks of row assembly, strobe order, settle/ready timing, reset and restart.
module tb_config_loader;
    localparam int NW = 301;

    logic         clock = 0;
    logic         rst = 0, start = 0, in_valid = 0;
    logic         in_ready, ff_en, rdy, busy;
    logic [31:0]  in_data = '0;
    logic [223:0] configs_in;
    logic [42:0]  configs_en;
    int           checks = 0, failures = 0;

    config_loader dut (
        .clock(clock), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .configs_in(configs_in), .configs_en(configs_en),
        .ff_en(ff_en), .rdy(rdy), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int w);
        logic [7:0] r, k;
        r = 8'(w / 7);
        k = 8'(w % 7);
        return {r, k, 16'hA5C3};
    endfunction

    function automatic logic [223:0] exp_row(input int r);
        logic [223:0] v;
        for (int k = 0; k < 7; k++) v[k*32 +: 32] = wd(r * 7 + k);
        return v;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_flags"}, {in_ready, busy, ff_en, rdy}, 4'b0);
        check({tag, "_en"}, configs_en, 0);
        check({tag, "_row"}, configs_in, 0);
    endtask

    // One load: start pulse, then per-cycle drive and sample on the falling edge
    task automatic load(input bit bp, input bit ign, input bit stall, input int stop_words);
        int w = 0, strobes = 0, cyc = 0, last = -100, ffc = -1, rdc = -1, scnt = 0;
        logic [42:0] e;
        @(negedge clock); start = 1;
        @(negedge clock); start = 0;
        check("start_ready", {in_ready, busy, ff_en, rdy}, 4'b1100);
        check("start_row", configs_in, 0);
        while (cyc < 4000) begin
            @(negedge clock);
            cyc++;
            start = 0;
            if (configs_en != 0) begin
                if (strobes < 43) begin
                    e = 43'(1) << strobes;
                    check("strobe_bit", configs_en, e);
                    check("row_data", configs_in, exp_row(strobes));
                    if (!bp && strobes > 0) check("spacing", cyc - last, 9);
                end else check("extra_strobe", configs_en, 0);
                strobes++;
                last = cyc;
            end
            if (stall && w == 4 && scnt > 0) begin
                check("stall_en", configs_en, 0);
                check("stall_row", configs_in, 0);
                check("stall_busy", busy, 1);
            end
            if (ff_en && ffc < 0) begin
                ffc = cyc;
                check("ffen_delay", cyc - last, 11);
                check("ffen_strobes", strobes, 43);
            end
            if (rdy && rdc < 0) begin
                rdc = cyc;
                check("rdy_delay", cyc - ffc, 10);
            end
            if (rdc >= 0 && cyc == rdc + 3) break;
            in_valid = w < NW ? (bp ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b1;
            in_data  = w < NW ? wd(w) : 32'hDEAD_BEEF;
            if (stall && w == 4 && scnt < 50) begin
                in_valid = 0;
                scnt++;
            end
            if (ign && (cyc == 60 || (strobes == 43 && cyc == last + 3))) start = 1;
            if (in_valid && in_ready) w++;
            if (stop_words != 0 && w == stop_words) return;
        end
        if (cyc >= 4000) check("timeout", 0, 1);
        check("strobes", strobes, 43);
        check("words", w, NW);
        check("done_flags", {in_ready, busy, ff_en, rdy}, 4'b0011);
        check("done_row", configs_in, exp_row(42));
        in_valid = 0;
    endtask

    initial begin
        rst = 1;
        repeat (3) @(negedge clock);
        rst = 0;
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_idle("idle");
        end
        in_valid = 0;
        load(0, 0, 0, 0);
        load(1, 0, 0, 0);
        load(0, 0, 0, 143);
        @(negedge clock);
        in_valid = 0;
        rst = 1;
        start = 1;
        @(negedge clock);
        rst = 0;
        start = 0;
        check_idle("midrst");
        load(0, 0, 0, 0);
        load(0, 1, 0, 0);
        load(0, 0, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
